audio_line_packer: RTL and testbench

//  Packs the CPU's 32-bit audio_out word stream into INPUT_SIZE-bit lines for the AudioProcessor.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_line_packer_if.sv | 27 ++
 rtl/audio_line_packer.sv | 94 +++++++++
 tb/tb_audio_line_packer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared sizing and state encoding for the audio line packer.
// Lines are INPUT_SIZE bits built from WORD_W-bit CPU words; a frame is LINES lines.
package audio_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned INPUT_SIZE = 512;
  localparam int unsigned SIZE       = 16;
  localparam int unsigned SAMPLES    = 2048;

  localparam int unsigned WPL   = INPUT_SIZE / WORD_W;
  localparam int unsigned LINES = SAMPLES * SIZE / INPUT_SIZE;
  localparam int unsigned IDXW  = $clog2(LINES);
  localparam int unsigned LANEW = $clog2(WPL);

  typedef enum logic [1:0] {
    StFill,
    StEmit,
    StStart
  } pack_state_t;

endpackage

// File: rtl/audio_line_packer_if.sv
// Word-in / line-out bundle between the CPU stream, the packer and the AudioProcessor
// LDE write port. master = stream/processor side, slave = packer.
interface audio_line_packer_if;
  import audio_pkg::*;

  logic                  word_valid;
  logic [WORD_W-1:0]     word_in;
  logic                  word_ready;
  logic                  flush;
  logic                  proc_busy;
  logic                  data_wr_en;
  logic [IDXW-1:0]       input_index;
  logic [INPUT_SIZE-1:0] data_in;
  logic                  frame_done;
  logic                  start;

  modport master (
    output word_valid, word_in, flush, proc_busy,
    input  word_ready, data_wr_en, input_index, data_in, frame_done, start
  );

  modport slave (
    input  word_valid, word_in, flush, proc_busy,
    output word_ready, data_wr_en, input_index, data_in, frame_done, start
  );

endinterface

// File: rtl/audio_line_packer.sv
// Packs 32-bit CPU audio words into INPUT_SIZE-bit lines and writes them to the AudioProcessor.
// Define AUDIO_AUTO_START_EN to pulse start (SYN) the cycle after each frame-final line write.
module audio_line_packer
  import audio_pkg::*;
(
  input logic                clk,
  input logic                rst,
  audio_line_packer_if.slave packer_io
);

  if (INPUT_SIZE % WORD_W != 0) begin : g_width_check
    $error("INPUT_SIZE must be a multiple of WORD_W");
  end

  pack_state_t           state_q, state_d;
  logic [LANEW-1:0]      lane_q, lane_d;
  logic [INPUT_SIZE-1:0] line_q, line_d;
  logic [IDXW-1:0]       idx_q, idx_d;

  logic word_ready, wr_en, frame_done, start;
  logic last_line;

  assign last_line = (idx_q == IDXW'(LINES - 1));

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    line_d     = line_q;
    idx_d      = idx_q;
    word_ready = 1'b0;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    start      = 1'b0;
    unique case (state_q)
      StFill: begin
        word_ready = 1'b1;
        if (packer_io.word_valid) begin
          line_d[lane_q * WORD_W +: WORD_W] = packer_io.word_in;
          lane_d = lane_q + 1'b1;
          // A flush coinciding with an accept still closes the line after this word.
          if (lane_q == LANEW'(WPL - 1) || packer_io.flush) begin
            state_d = StEmit;
          end
        end else if (packer_io.flush && lane_q != '0) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (!packer_io.proc_busy) begin
          wr_en      = 1'b1;
          frame_done = last_line;
          line_d     = '0;
          lane_d     = '0;
          idx_d      = last_line ? '0 : idx_q + 1'b1;
          state_d    = StFill;
`ifdef AUDIO_AUTO_START_EN
          if (last_line) begin
            state_d = StStart;
          end
`endif
        end
      end
      StStart: begin
`ifdef AUDIO_AUTO_START_EN
        start = 1'b1;
`endif
        state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      lane_q  <= '0;
      line_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
    end
  end

  assign packer_io.word_ready  = word_ready;
  assign packer_io.data_wr_en  = wr_en;
  assign packer_io.input_index = idx_q;
  assign packer_io.data_in     = line_q;
  assign packer_io.frame_done  = frame_done;
  assign packer_io.start       = start;

endmodule

// File: tb/tb_audio_line_packer.sv
// Directed bench for audio_line_packer: a line model queues each expected write and a
// negedge monitor pops and compares it when data_wr_en fires.
module tb_audio_line_packer;
  import audio_pkg::*;

`ifdef AUDIO_AUTO_START_EN
  localparam bit AutoStart = 1'b1;
`else
  localparam bit AutoStart = 1'b0;
`endif

  typedef struct {
    logic [IDXW-1:0]       idx;
    logic [INPUT_SIZE-1:0] data;
    logic                  fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_line_packer_if bus_if();

  audio_line_packer dut (
    .clk       (clk),
    .rst       (rst),
    .packer_io (bus_if)
  );

  int compared   = 0;
  int mismatched = 0;
  int wr_cnt     = 0;
  int fd_cnt     = 0;
  bit fd_prev    = 1'b0;

  exp_t                  sb[$];
  logic [INPUT_SIZE-1:0] m_line;
  int                    m_lane;
  logic [IDXW-1:0]       m_idx;

  task automatic check(input string tag, input logic [INPUT_SIZE-1:0] obs,
                       input logic [INPUT_SIZE-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_line = '0;
    m_lane = 0;
    m_idx  = '0;
  endfunction

  function automatic void model_emit();
    exp_t e;
    e.idx  = m_idx;
    e.data = m_line;
    e.fd   = (m_idx == IDXW'(LINES - 1));
    sb.push_back(e);
    m_line = '0;
    m_lane = 0;
    m_idx  = e.fd ? '0 : m_idx + 1'b1;
  endfunction

  task automatic push_word(input logic [WORD_W-1:0] w);
    int n = 0;
    bus_if.word_valid = 1'b1;
    bus_if.word_in    = w;
    while (bus_if.word_ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    check("push_ready", {511'd0, bus_if.word_ready}, 1);
    m_line[m_lane * WORD_W +: WORD_W] = w;
    m_lane++;
    if (m_lane == int'(WPL) || bus_if.flush) model_emit();
    cyc();
    bus_if.word_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus_if.flush = 1'b1;
    cyc();
    bus_if.flush = 1'b0;
    if (m_lane > 0) model_emit();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Scoreboard consumer plus start/frame_done sanity.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      fd_prev = 1'b0;
    end else begin
      if (bus_if.start || (AutoStart && fd_prev)) begin
        check("start", {511'd0, bus_if.start}, {511'd0, AutoStart && fd_prev});
        if (AutoStart && fd_prev) check("ready_in_start", {511'd0, bus_if.word_ready}, 0);
      end
      if (bus_if.data_wr_en) begin
        wr_cnt++;
        if (bus_if.frame_done) fd_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          check("input_index", bus_if.input_index, e.idx);
          check("data_in", bus_if.data_in, e.data);
          check("frame_done", {511'd0, bus_if.frame_done}, {511'd0, e.fd});
        end
      end else if (bus_if.frame_done) begin
        check("frame_done_without_write", 1, 0);
      end
      fd_prev = bus_if.data_wr_en & bus_if.frame_done;
    end
  end

  initial begin
    int w0;
    int f0;
    bus_if.word_valid = 1'b0;
    bus_if.word_in    = '0;
    bus_if.flush      = 1'b0;
    bus_if.proc_busy  = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;

    check("rst_word_ready", {511'd0, bus_if.word_ready}, 1);
    check("rst_data_wr_en", {511'd0, bus_if.data_wr_en}, 0);
    check("rst_frame_done", {511'd0, bus_if.frame_done}, 0);
    check("rst_start", {511'd0, bus_if.start}, 0);
    check("rst_input_index", bus_if.input_index, 0);
    check("rst_data_in", bus_if.data_in, 0);

    // Full line of 1..16.
    w0 = wr_cnt;
    for (int i = 1; i <= 16; i++) push_word(WORD_W'(i));
    drain();
    check("t1_writes", wr_cnt - w0, 1);

    // Partial line closed by flush.
    w0 = wr_cnt;
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    do_flush();
    drain();
    check("t2_writes", wr_cnt - w0, 1);

    // Completed line held by proc_busy.
    w0 = wr_cnt;
    for (int i = 0; i < 15; i++) push_word($urandom);
    bus_if.proc_busy = 1'b1;
    push_word($urandom);
    for (int i = 0; i < 5; i++) begin
      check("busy_ready", {511'd0, bus_if.word_ready}, 0);
      check("busy_wr_en", {511'd0, bus_if.data_wr_en}, 0);
      check("busy_data_stable", bus_if.data_in, sb[$].data);
      cyc();
    end
    bus_if.proc_busy = 1'b0;
    drain();
    check("t3_writes", wr_cnt - w0, 1);

    // Reset mid-line.
    w0 = wr_cnt;
    for (int i = 0; i < 7; i++) push_word($urandom);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    check("rst_mid_index", bus_if.input_index, 0);
    check("rst_mid_data", bus_if.data_in, 0);
    for (int i = 0; i < 16; i++) push_word($urandom);
    drain();
    check("t5_writes", wr_cnt - w0, 1);

    // Reset while a line waits in EMIT.
    w0 = wr_cnt;
    bus_if.proc_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_word($urandom);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus_if.proc_busy = 1'b0;
    void'(sb.pop_back());
    model_reset();
    repeat (3) cyc();
    check("rst_emit_writes", wr_cnt - w0, 0);
    check("rst_emit_ready", {511'd0, bus_if.word_ready}, 1);

    // Flush on an empty line, then flush with the 16th word.
    w0 = wr_cnt;
    do_flush();
    repeat (3) cyc();
    check("t6_empty_flush_writes", wr_cnt - w0, 0);
    for (int i = 0; i < 15; i++) push_word($urandom);
    bus_if.flush = 1'b1;
    push_word($urandom);
    bus_if.flush = 1'b0;
    repeat (3) cyc();
    drain();
    check("t6_flush_full_writes", wr_cnt - w0, 1);

    // Whole frame plus one line from index 0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    w0 = wr_cnt;
    f0 = fd_cnt;
    for (int l = 0; l < int'(LINES) + 1; l++) begin
      for (int i = 0; i < int'(WPL); i++) push_word($urandom);
    end
    drain();
    repeat (3) cyc();
    check("t4_writes", wr_cnt - w0, LINES + 1);
    check("t4_frame_done_count", fd_cnt - f0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
